data_cache: RTL and testbench

// - Direct-mapped, write-back, write-allocate data cache between the MEM stage and data_memory.
// - Serves byte, half-word and word loads and stores from 128-bit lines (16 bytes per line).
// - On a miss it initiates block transfers using data_memory's READ_EN/WRITE_EN/BUSYWAIT handshake.
// - Stalls the pipeline through CPU_BUSYWAIT.

---
 rtl/data_cache_pkg.sv | 19 +
 rtl/data_cache_load_align.sv | 29 ++
 rtl/data_cache.sv | 145 ++++++++++++++
 tb/tb_data_cache.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package data_cache_pkg;

  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_BACK,
    ST_MEM_READ,
    ST_UPDATE
  } cache_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_cache_load_align.sv
// Selects the addressed byte/half/word from a cache line and extends it for the load.
module cache_load_align
  import data_cache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [3:0]        offset,
  input  logic [2:0]        func3,
  output logic [31:0]       data
);

  logic [31:0] word;
  logic [15:0] half;
  logic [7:0]  byte_v;

  // Low offset bits below the access size are ignored, so misaligned accesses round down.
  always_comb begin
    word   = line[{offset[3:2], 5'd0} +: 32];
    half   = word[{offset[1], 4'd0} +: 16];
    byte_v = word[{offset[1:0], 3'd0} +: 8];
    case (func3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'd0, byte_v};
      F3_H:    data = {{16{half[15]}}, half};
      F3_HU:   data = {16'd0, half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines,
// refilling/evicting through the data_memory READ_EN/WRITE_EN/BUSYWAIT handshake.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CPU_READ,
  input  logic              CPU_WRITE,
  input  logic [2:0]        CPU_FUNC3,
  input  logic [31:0]       CPU_ADDRESS,
  input  logic [31:0]       CPU_WRITEDATA,
  output logic [31:0]       CPU_READDATA,
  output logic              CPU_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [27:0]       MEM_ADDRESS,
  output logic [LINE_W-1:0] MEM_WRITEDATA,
  input  logic [LINE_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  localparam int unsigned INDEX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W   = 28 - INDEX_W;

  cache_state_t state_q, state_d;

  logic [LINE_W-1:0]   line_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [3:0]         offset;
  logic               access;
  logic               hit;
  logic               wr_hit;
  logic [LINE_W-1:0]  cur_line;
  logic [LINE_W-1:0]  wmask;
  logic [LINE_W-1:0]  wdata_rep;
  logic [LINE_W-1:0]  merged_line;
  logic [15:0]        byte_en;
  logic [31:0]        load_data;

  assign idx      = CPU_ADDRESS[4 +: INDEX_W];
  assign cpu_tag  = CPU_ADDRESS[31 -: TAG_W];
  assign offset   = CPU_ADDRESS[3:0];
  assign access   = CPU_READ ^ CPU_WRITE;
  assign cur_line = line_q[idx];
  assign hit      = valid_q[idx] && (tag_q[idx] == cpu_tag);
  assign wr_hit   = (state_q == ST_IDLE) && access && CPU_WRITE && hit;

  assign CPU_BUSYWAIT = (access && !hit) || (state_q != ST_IDLE);
  assign CPU_READDATA = ((state_q == ST_IDLE) && access && CPU_READ && hit) ? load_data : '0;

  cache_load_align u_load_align (
    .line   (cur_line),
    .offset (offset),
    .func3  (CPU_FUNC3),
    .data   (load_data)
  );

  // Store data is replicated across the line; the byte enables pick which copy lands.
  always_comb begin
    case (CPU_FUNC3[1:0])
      2'b00: begin
        byte_en   = 16'h0001 << offset;
        wdata_rep = {16{CPU_WRITEDATA[7:0]}};
      end
      2'b01: begin
        byte_en   = 16'h0003 << {offset[3:1], 1'b0};
        wdata_rep = {8{CPU_WRITEDATA[15:0]}};
      end
      default: begin
        byte_en   = 16'h000F << {offset[3:2], 2'b00};
        wdata_rep = {4{CPU_WRITEDATA}};
      end
    endcase
    wmask = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      wmask[8*i +: 8] = {8{byte_en[i]}};
    end
    merged_line = (cur_line & ~wmask) | (wdata_rep & wmask);
  end

  always_comb begin
    state_d       = state_q;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      ST_IDLE: begin
        if (access && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? ST_WRITE_BACK : ST_MEM_READ;
        end
      end
      ST_WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = cur_line;
        if (!MEM_BUSYWAIT) state_d = ST_MEM_READ;
      end
      ST_MEM_READ: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = CPU_ADDRESS[31:4];
        if (!MEM_BUSYWAIT) state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_UPDATE) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Line data and tags need no reset; valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == ST_UPDATE) begin
        line_q[idx] <= MEM_READDATA;
        tag_q[idx]  <= cpu_tag;
      end else if (wr_hit) begin
        line_q[idx] <= merged_line;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache against a 16-cycle data_memory model.
module tb_data_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         CPU_READ = 1'b0;
  logic         CPU_WRITE = 1'b0;
  logic [2:0]   CPU_FUNC3 = 3'b000;
  logic [31:0]  CPU_ADDRESS = '0;
  logic [31:0]  CPU_WRITEDATA = '0;
  logic [31:0]  CPU_READDATA;
  logic         CPU_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] mem_rdata = '0;
  logic         mem_busy;

  data_cache #(.NUM_SETS(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .CPU_READ      (CPU_READ),
    .CPU_WRITE     (CPU_WRITE),
    .CPU_FUNC3     (CPU_FUNC3),
    .CPU_ADDRESS   (CPU_ADDRESS),
    .CPU_WRITEDATA (CPU_WRITEDATA),
    .CPU_READDATA  (CPU_READDATA),
    .CPU_BUSYWAIT  (CPU_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (mem_rdata),
    .MEM_BUSYWAIT  (mem_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int unsigned stall;
    int          id;
  } exp_t;

  typedef struct {
    logic         we;
    logic [27:0]  addr;
    logic [127:0] data;
  } mexp_t;

  exp_t  exp_q[$];
  mexp_t exp_mem[$];
  int    probe_q[$];

  int checks = 0;
  int errors = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;

  // Block 0 holds bytes 0x80,0x7F,0x7E,...; every other block b has word w = 0xC0DE0000|(b<<4)|w.
  function automatic logic [127:0] blk(input logic [27:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'h80 - 8'(i);
    if (a != 28'd0) begin
      for (int w = 0; w < 4; w++) r[32*w +: 32] = 32'hC0DE0000 | (32'(a) << 4) | 32'(w);
    end
    return r;
  endfunction

  // data_memory model: busy from the first enabled cycle, low in the 16th.
  int unsigned  mcnt = 0;
  logic         mdone = 1'b0;
  logic         mdone_we = 1'b0;
  logic [27:0]  mdone_addr = '0;
  logic [127:0] mdone_data = '0;

  assign mem_busy = (MEM_READ || MEM_WRITE) && (mcnt != 15);

  always @(posedge CLK) begin
    mdone <= 1'b0;
    if (!(MEM_READ || MEM_WRITE)) begin
      mcnt <= 0;
    end else if (mcnt == 15) begin
      mcnt       <= 0;
      mdone      <= 1'b1;
      mdone_we   <= MEM_WRITE;
      mdone_addr <= MEM_ADDRESS;
      mdone_data <= MEM_WRITEDATA;
      if (MEM_READ) mem_rdata <= blk(MEM_ADDRESS);
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  task automatic cmp(input string what, input int id, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h expected %h", what, id, act, exp);
    end
  endtask

  int unsigned stall_cnt = 0;

  always @(negedge CLK) begin : monitor
    exp_t  e;
    mexp_t m;
    int    pid;
    if (RESET || !(CPU_READ ^ CPU_WRITE)) begin
      stall_cnt = 0;
    end else if (CPU_BUSYWAIT) begin
      stall_cnt++;
    end else begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_completion", -1, 128'(CPU_ADDRESS), 128'hX);
      end else begin
        e = exp_q.pop_front();
        if (e.rd) cmp("rd_data", e.id, 128'(CPU_READDATA), 128'(e.data));
        cmp("stall_cycles", e.id, 128'(stall_cnt), 128'(e.stall));
      end
      stall_cnt = 0;
    end

    if (MEM_READ && MEM_WRITE) cmp("both_enables", -1, 128'(1), 128'(0));

    if (mdone) begin
      if (exp_mem.size() == 0) begin
        cmp("unexpected_mem_xfer", -1, 128'(mdone_addr), 128'hX);
      end else begin
        m = exp_mem.pop_front();
        cmp("mem_is_write", -1, 128'(mdone_we), 128'(m.we));
        cmp("mem_addr", -1, 128'(mdone_addr), 128'(m.addr));
        if (m.we) cmp("mem_wdata", -1, mdone_data, m.data);
      end
    end

    if (probe_q.size() != 0) begin
      pid = probe_q.pop_front();
      cmp("idle_busywait", pid, 128'(CPU_BUSYWAIT), 128'(0));
      cmp("idle_mem_read", pid, 128'(MEM_READ), 128'(0));
      cmp("idle_mem_write", pid, 128'(MEM_WRITE), 128'(0));
      cmp("idle_mem_addr", pid, 128'(MEM_ADDRESS), 128'(0));
      cmp("idle_mem_wdata", pid, MEM_WRITEDATA, 128'(0));
      cmp("idle_rdata", pid, 128'(CPU_READDATA), 128'(0));
    end

    if (final_req && !final_done) begin
      cmp("leftover_accesses", -1, 128'(exp_q.size()), 128'(0));
      cmp("leftover_mem_xfers", -1, 128'(exp_mem.size()), 128'(0));
      final_done = 1'b1;
    end
  end

  int acc_id = 0;

  task automatic mem_exp(input logic we, input logic [27:0] a, input logic [127:0] d);
    mexp_t m;
    m.we = we; m.addr = a; m.data = d;
    exp_mem.push_back(m);
  endtask

  task automatic access(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d, input int unsigned stall);
    exp_t e;
    int   n;
    e.rd = rd; e.data = exp_d; e.stall = stall; e.id = acc_id;
    exp_q.push_back(e);
    acc_id++;
    CPU_READ = rd; CPU_WRITE = !rd; CPU_FUNC3 = f3; CPU_ADDRESS = a; CPU_WRITEDATA = wd;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (CPU_BUSYWAIT && n < 200);
    if (CPU_BUSYWAIT) begin
      $display("FAIL access_timeout #%0d: busywait still 1 after %0d cycles, required 0", e.id, n);
      $fatal(1, "access timeout");
    end
    @(posedge CLK); #1;
    CPU_READ = 1'b0; CPU_WRITE = 1'b0;
    @(posedge CLK); #1;
  endtask

  logic [127:0] evict_line;

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    probe_q.push_back(100);
    @(posedge CLK); #1;

    // Cold miss, then hits from the filled line.
    mem_exp(1'b0, 28'h0000000, '0);
    access(1'b1, 3'b010, 32'h0, 32'h0, 32'h7D7E7F80, 18);
    access(1'b1, 3'b000, 32'h0, 32'h0, 32'hFFFFFF80, 0);
    access(1'b1, 3'b100, 32'h0, 32'h0, 32'h00000080, 0);
    access(1'b1, 3'b001, 32'h0, 32'h0, 32'h00007F80, 0);
    access(1'b1, 3'b000, 32'h1, 32'h0, 32'h0000007F, 0);
    access(1'b1, 3'b101, 32'h1, 32'h0, 32'h00007F80, 0);
    access(1'b1, 3'b001, 32'h2, 32'h0, 32'h00007D7E, 0);

    // Store hits: only the low byte of sb data is used.
    access(1'b0, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 0);
    access(1'b0, 3'b000, 32'hB, 32'hAAAAAA11, 32'h0, 0);
    access(1'b1, 3'b010, 32'h8, 32'h0, 32'h11ADBEEF, 0);
    access(1'b1, 3'b010, 32'h9, 32'h0, 32'h11ADBEEF, 0);
    access(1'b1, 3'b100, 32'hB, 32'h0, 32'h00000011, 0);
    access(1'b1, 3'b001, 32'hA, 32'h0, 32'h000011AD, 0);

    // Conflict miss on a dirty victim: write-back of block 0, then refill of block 8.
    evict_line = blk(28'h0);
    evict_line[95:64] = 32'h11ADBEEF;
    mem_exp(1'b1, 28'h0000000, evict_line);
    mem_exp(1'b0, 28'h0000008, '0);
    access(1'b1, 3'b010, 32'h80, 32'h0, 32'hC0DE0080, 34);

    // Write-allocate of a misaligned sh into an empty set.
    mem_exp(1'b0, 28'h0000003, '0);
    access(1'b0, 3'b001, 32'h37, 32'hFFFF1234, 32'h0, 18);
    access(1'b1, 3'b010, 32'h34, 32'h0, 32'h12340031, 0);
    access(1'b1, 3'b001, 32'h36, 32'h0, 32'h00001234, 0);
    access(1'b1, 3'b000, 32'h37, 32'h0, 32'h00000012, 0);

    // Read and write together is no access, even to a missing address.
    CPU_READ = 1'b1; CPU_WRITE = 1'b1; CPU_FUNC3 = 3'b010; CPU_ADDRESS = 32'h200;
    probe_q.push_back(101);
    @(posedge CLK); #1;
    CPU_READ = 1'b0; CPU_WRITE = 1'b0;
    probe_q.push_back(102);
    @(posedge CLK); #1;

    // Reset in the 5th MEM_READ cycle aborts the refill.
    CPU_READ = 1'b1; CPU_FUNC3 = 3'b010; CPU_ADDRESS = 32'h100;
    n = 0;
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge CLK);
      if (MEM_READ) n++;
    end
    if (n < 5) begin
      $display("FAIL mem_read_start: saw %0d MEM_READ cycles, required 5", n);
      $fatal(1, "refill never started");
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; CPU_READ = 1'b0;
    probe_q.push_back(103);
    @(posedge CLK); #1;
    probe_q.push_back(104);
    @(posedge CLK); #1;

    // All lines invalid and clean again: both re-reads are plain refills.
    mem_exp(1'b0, 28'h0000008, '0);
    access(1'b1, 3'b010, 32'h80, 32'h0, 32'hC0DE0080, 18);
    mem_exp(1'b0, 28'h0000003, '0);
    access(1'b1, 3'b010, 32'h34, 32'h0, 32'hC0DE0031, 18);

    repeat (3) @(posedge CLK);
    final_req = 1'b1;
    n = 0;
    while (!final_done && n < 10) begin
      @(posedge CLK);
      n++;
    end
    #1;
    if (!final_done) begin
      $display("FAIL final_scoreboard: monitor did not respond, required a response");
      $fatal(1, "monitor stalled");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
